// File: rtl/ni_multi_vc_wb_slave_regs.sv
// Multi-VC network-interface register bank behind a Wishbone slave port.
// Each VC has its own send/receive descriptor set. A global block holds the
// maskable done-interrupt. Receive starts are arbitrated lowest-VC-first.
// Block index must be wide enough to encode V (S_Aw-4 > log2(V)).
module ni_multi_vc_wb_slave_regs #(
    parameter int V = 4,
    parameter int MAX_TRANSACTION_WIDTH = 10,
    parameter int EAw = 4,
    parameter int C = 4,
    parameter int WEIGHTw = 4,
    parameter int Dw = 32,
    parameter int S_Aw = 7,
    localparam int Cw = (C > 1) ? $clog2(C) : 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                state_reg_enable,
    input  logic [V-1:0]                        send_fsm_is_ideal,
    input  logic [V-1:0]                        receive_fsm_is_ideal,
    input  logic [V-1:0]                        receive_vc_got_packet,
    input  logic [V-1:0]                        receive_done,
    input  logic [V-1:0]                        send_done,
    input  logic                                all_save_done_reg_rst,
    input  logic [Dw-1:0]                       s_dat_i,
    input  logic [S_Aw-1:0]                     s_addr_i,
    input  logic                                s_stb_i,
    input  logic                                s_cyc_i,
    input  logic                                s_we_i,
    output logic [Dw-1:0]                       s_dat_o,
    output logic                                s_ack_o,
    output logic [V*Dw-1:0]                     send_start_addr,
    output logic [V*Dw-1:0]                     receive_start_addr,
    output logic [V*MAX_TRANSACTION_WIDTH-1:0]  send_data_size,
    output logic [V*MAX_TRANSACTION_WIDTH-1:0]  max_receive_buff_siz,
    output logic [V*EAw-1:0]                    dest_e_addr,
    output logic [V*Cw-1:0]                     pck_class,
    output logic [V*WEIGHTw-1:0]                weight,
    output logic [V-1:0]                        send_start,
    output logic [V-1:0]                        receive_start,
    output logic [V-1:0]                        receive_packet_is_saved,
    output logic                                irq
);
    localparam int OFFSET_w = $clog2(Dw / 8);
    localparam int BLK_W    = S_Aw - 4;
    localparam int VW       = (V > 1) ? $clog2(V) : 1;
    localparam int MTW      = MAX_TRANSACTION_WIDTH;

    logic [Dw-1:0]      send_addr_r [V];
    logic [Dw-1:0]      recv_addr_r [V];
    logic [MTW-1:0]     send_size_r [V];
    logic [MTW-1:0]     recv_max_r  [V];
    logic [EAw-1:0]     dest_r      [V];
    logic [Cw-1:0]      class_r     [V];
    logic [WEIGHTw-1:0] weight_r    [V];
    logic [V-1:0]       send_start_r, receive_en_r, saved_r;
    logic [2*V-1:0]     irq_status_r, irq_enable_r;
    logic               irq_r, ack_r;
    logic [Dw-1:0]      dat_r;

    logic               acc_s, wr_s, glb_wr_s;
    logic [BLK_W-1:0]   blk_s;
    logic [VW-1:0]      vc_s;
    logic [3:0]         off_s;
    logic [Dw-1:0]      word_addr_s, rd_data_s;
    logic [V-1:0]       vc_wr_s, tx_wr_s, rx_wr_s, recv_ctrl_wr_s, req_s, grant_s;
    logic [2*V-1:0]     irq_w1c_s;

    assign acc_s       = s_stb_i & s_cyc_i & ~ack_r;
    assign wr_s        = acc_s & s_we_i & state_reg_enable;
    assign blk_s       = s_addr_i[S_Aw-1:4];
    assign vc_s        = blk_s[VW-1:0];
    assign off_s       = s_addr_i[3:0];
    assign word_addr_s = s_dat_i >> OFFSET_w;
    assign glb_wr_s    = wr_s & (blk_s == BLK_W'(V));

    // Decode which VC block a committed write targets, gated by FSM idleness
    always_comb begin
        vc_wr_s = '0;
        for (int v = 0; v < V; v++) begin
            vc_wr_s[v] = wr_s & (blk_s == BLK_W'(v));
        end
        tx_wr_s        = vc_wr_s & send_fsm_is_ideal;
        rx_wr_s        = vc_wr_s & receive_fsm_is_ideal;
        recv_ctrl_wr_s = rx_wr_s & {V{off_s == 4'd10}};
        irq_w1c_s      = (glb_wr_s && (off_s == 4'd0)) ? s_dat_i[2*V-1:0] : '0;
    end

    // Lowest-index receive request wins; at most one receive launches per cycle
    assign req_s   = receive_fsm_is_ideal & receive_vc_got_packet & receive_en_r;
    assign grant_s = req_s & (~req_s + V'(1'b1));

    // Per-VC send/receive descriptor registers and send-start pulse
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int v = 0; v < V; v++) begin
                send_addr_r[v] <= '0;
                recv_addr_r[v] <= '0;
                send_size_r[v] <= '0;
                recv_max_r[v]  <= '0;
                dest_r[v]      <= '0;
                class_r[v]     <= '0;
                weight_r[v]    <= WEIGHTw'(1'b1);
            end
            send_start_r <= '0;
        end else begin
            send_start_r <= '0;
            for (int v = 0; v < V; v++) begin
                if (tx_wr_s[v]) begin
                    case (off_s)
                        4'd3: send_size_r[v] <= s_dat_i[MTW-1:0];
                        4'd4: send_addr_r[v] <= word_addr_s;
                        4'd5: begin
                            dest_r[v]       <= s_dat_i[EAw-1:0];
                            class_r[v]      <= s_dat_i[16 +: Cw];
                            weight_r[v]     <= s_dat_i[24 +: WEIGHTw];
                            send_start_r[v] <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                if (rx_wr_s[v]) begin
                    case (off_s)
                        4'd8:    recv_addr_r[v] <= word_addr_s;
                        4'd11:   recv_max_r[v]  <= s_dat_i[MTW-1:0];
                        default: ;
                    endcase
                end
            end
        end
    end

    // Receive enable and saved flags; RECV_CTRL write beats completion/clear
    always_ff @(posedge clk) begin
        if (!reset) begin
            receive_en_r <= '0;
            saved_r      <= '0;
        end else begin
            for (int v = 0; v < V; v++) begin
                if (recv_ctrl_wr_s[v]) begin
                    receive_en_r[v] <= 1'b1;
                end else if (grant_s[v]) begin
                    receive_en_r[v] <= 1'b0;
                end
                if (recv_ctrl_wr_s[v]) begin
                    saved_r[v] <= 1'b0;
                end else if (receive_done[v]) begin
                    saved_r[v] <= 1'b1;
                end else if (all_save_done_reg_rst) begin
                    saved_r[v] <= 1'b0;
                end
            end
        end
    end

    // Interrupt status (W1C, set wins), enable mask and registered irq
    always_ff @(posedge clk) begin
        if (!reset) begin
            irq_status_r <= '0;
            irq_enable_r <= '0;
            irq_r        <= 1'b0;
        end else begin
            irq_status_r <= (irq_status_r & ~irq_w1c_s) | {receive_done, send_done};
            if (glb_wr_s && (off_s == 4'd1)) begin
                irq_enable_r <= s_dat_i[2*V-1:0];
            end
            irq_r <= |(irq_status_r & irq_enable_r);
        end
    end

    // Readback mux; unmapped blocks and offsets read as zero
    always_comb begin
        rd_data_s = '0;
        if (blk_s < BLK_W'(V)) begin
            case (off_s)
                4'd0: rd_data_s[4:0] = {receive_vc_got_packet[vc_s], saved_r[vc_s],
                                        receive_en_r[vc_s], receive_fsm_is_ideal[vc_s],
                                        send_fsm_is_ideal[vc_s]};
                4'd3: rd_data_s[MTW-1:0] = send_size_r[vc_s];
                4'd4: rd_data_s = send_addr_r[vc_s];
                4'd5: begin
                    rd_data_s[EAw-1:0]      = dest_r[vc_s];
                    rd_data_s[16 +: Cw]     = class_r[vc_s];
                    rd_data_s[24 +: WEIGHTw] = weight_r[vc_s];
                end
                4'd8:  rd_data_s = recv_addr_r[vc_s];
                4'd11: rd_data_s[MTW-1:0] = recv_max_r[vc_s];
                default: rd_data_s = '0;
            endcase
        end else if (blk_s == BLK_W'(V)) begin
            case (off_s)
                4'd0:    rd_data_s[2*V-1:0] = irq_status_r;
                4'd1:    rd_data_s[2*V-1:0] = irq_enable_r;
                default: rd_data_s = '0;
            endcase
        end else begin
            rd_data_s = '0;
        end
    end

    // Registered ack and read data; every access completes in two cycles
    always_ff @(posedge clk) begin
        if (!reset) begin
            ack_r <= 1'b0;
            dat_r <= '0;
        end else begin
            ack_r <= acc_s;
            if (acc_s) begin
                dat_r <= rd_data_s;
            end
        end
    end

    // Flatten per-VC registers onto the packed output buses
    for (genvar g = 0; g < V; g++) begin : g_flat
        assign send_start_addr[g*Dw +: Dw]         = send_addr_r[g];
        assign receive_start_addr[g*Dw +: Dw]      = recv_addr_r[g];
        assign send_data_size[g*MTW +: MTW]        = send_size_r[g];
        assign max_receive_buff_siz[g*MTW +: MTW]  = recv_max_r[g];
        assign dest_e_addr[g*EAw +: EAw]           = dest_r[g];
        assign pck_class[g*Cw +: Cw]               = class_r[g];
        assign weight[g*WEIGHTw +: WEIGHTw]        = weight_r[g];
    end

    assign send_start              = send_start_r;
    assign receive_start           = grant_s;
    assign receive_packet_is_saved = saved_r;
    assign irq                     = irq_r;
    assign s_ack_o                 = ack_r;
    assign s_dat_o                 = dat_r;
endmodule

// File: tb/tb_ni_multi_vc_wb_slave_regs.sv
// Directed self-checking bench for ni_multi_vc_wb_slave_regs (V=4, Dw=32).
module tb_ni_multi_vc_wb_slave_regs;
    logic         clk = 1'b0;
    logic         reset;
    logic         state_reg_enable;
    logic [3:0]   send_fsm_is_ideal, receive_fsm_is_ideal;
    logic [3:0]   receive_vc_got_packet, receive_done, send_done;
    logic         all_save_done_reg_rst;
    logic [31:0]  s_dat_i;
    logic [6:0]   s_addr_i;
    logic         s_stb_i, s_cyc_i, s_we_i;
    logic [31:0]  s_dat_o;
    logic         s_ack_o;
    logic [127:0] send_start_addr, receive_start_addr;
    logic [39:0]  send_data_size, max_receive_buff_siz;
    logic [15:0]  dest_e_addr;
    logic [7:0]   pck_class;
    logic [15:0]  weight;
    logic [3:0]   send_start, receive_start, receive_packet_is_saved;
    logic         irq;

    int checks = 0;
    int errors = 0;
    logic [31:0] rd;

    ni_multi_vc_wb_slave_regs dut (
        .clk(clk), .reset(reset), .state_reg_enable(state_reg_enable),
        .send_fsm_is_ideal(send_fsm_is_ideal), .receive_fsm_is_ideal(receive_fsm_is_ideal),
        .receive_vc_got_packet(receive_vc_got_packet), .receive_done(receive_done),
        .send_done(send_done), .all_save_done_reg_rst(all_save_done_reg_rst),
        .s_dat_i(s_dat_i), .s_addr_i(s_addr_i), .s_stb_i(s_stb_i), .s_cyc_i(s_cyc_i),
        .s_we_i(s_we_i), .s_dat_o(s_dat_o), .s_ack_o(s_ack_o),
        .send_start_addr(send_start_addr), .receive_start_addr(receive_start_addr),
        .send_data_size(send_data_size), .max_receive_buff_siz(max_receive_buff_siz),
        .dest_e_addr(dest_e_addr), .pck_class(pck_class), .weight(weight),
        .send_start(send_start), .receive_start(receive_start),
        .receive_packet_is_saved(receive_packet_is_saved), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One Wishbone access: strobe at a negedge, ack expected at the next negedge
    task automatic wb(input logic we, input logic [2:0] blk, input logic [3:0] off,
                      input logic [31:0] data, output logic [31:0] rdata);
        @(negedge clk);
        s_addr_i = {blk, off};
        s_dat_i  = data;
        s_we_i   = we;
        s_stb_i  = 1'b1;
        s_cyc_i  = 1'b1;
        @(negedge clk);
        check("ack_high", s_ack_o, 1'b1);
        rdata   = s_dat_o;
        s_stb_i = 1'b0;
        s_cyc_i = 1'b0;
        s_we_i  = 1'b0;
    endtask

    initial begin
        reset = 1'b0; state_reg_enable = 1'b1;
        send_fsm_is_ideal = 4'hF; receive_fsm_is_ideal = 4'hF;
        receive_vc_got_packet = 4'h0; receive_done = 4'h0; send_done = 4'h0;
        all_save_done_reg_rst = 1'b0;
        s_dat_i = 32'h0; s_addr_i = 7'h0; s_stb_i = 1'b0; s_cyc_i = 1'b0; s_we_i = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ack", s_ack_o, 1'b0);
        check("rst_dat", s_dat_o, 32'h0);
        check("rst_weight", weight, 16'h1111);
        check("rst_dest", dest_e_addr, 16'h0);
        check("rst_send_start", send_start, 4'h0);
        check("rst_irq", irq, 1'b0);
        check("rst_saved", receive_packet_is_saved, 4'h0);
        reset = 1'b1;

        // SEND_DEST on VC2
        wb(1'b1, 3'd2, 4'd5, 32'h0302_0005, rd);
        check("dest_start_pulse", send_start, 4'b0100);
        check("dest_vc2", dest_e_addr, 16'h0500);
        check("class_vc2", pck_class, 8'h20);
        check("weight_vc2", weight, 16'h1311);
        @(negedge clk);
        check("dest_start_gone", send_start, 4'b0000);
        wb(1'b0, 3'd2, 4'd5, 32'h0, rd);
        check("dest_readback", rd, 32'h0302_0005);

        // SEND_STRT on VC1 with ack timing
        wb(1'b1, 3'd1, 4'd4, 32'h100, rd);
        check("strt_addr", send_start_addr, 128'h40 << 32);
        @(negedge clk);
        check("ack_low_after", s_ack_o, 1'b0);
        wb(1'b0, 3'd1, 4'd4, 32'h0, rd);
        check("strt_readback", rd, 32'h40);

        // Receive arbitration across VC0 and VC3
        wb(1'b1, 3'd0, 4'd10, 32'h1, rd);
        wb(1'b1, 3'd3, 4'd10, 32'h1, rd);
        @(negedge clk);
        check("rx_idle_start", receive_start, 4'b0000);
        receive_vc_got_packet = 4'b1001;
        #1;
        check("rx_grant0", receive_start, 4'b0001);
        @(negedge clk);
        check("rx_grant3", receive_start, 4'b1000);
        @(negedge clk);
        check("rx_grant_none", receive_start, 4'b0000);
        receive_vc_got_packet = 4'b0000;
        wb(1'b0, 3'd3, 4'd0, 32'h0, rd);
        check("status_vc3", rd, 32'h3);

        // Saved flag priority and done interrupt
        wb(1'b1, 3'd4, 4'd1, 32'h20, rd);
        @(negedge clk);
        receive_done = 4'b0010;
        @(negedge clk);
        receive_done = 4'b0000;
        check("saved_set", receive_packet_is_saved, 4'b0010);
        check("irq_lag", irq, 1'b0);
        @(negedge clk);
        check("irq_set", irq, 1'b1);
        s_addr_i = {3'd1, 4'd10}; s_dat_i = 32'h1; s_we_i = 1'b1;
        s_stb_i = 1'b1; s_cyc_i = 1'b1; receive_done = 4'b0010;
        @(negedge clk);
        receive_done = 4'b0000; s_stb_i = 1'b0; s_cyc_i = 1'b0; s_we_i = 1'b0;
        check("ctrl_ack", s_ack_o, 1'b1);
        check("saved_ctrl_wins", receive_packet_is_saved, 4'b0000);
        wb(1'b0, 3'd4, 4'd0, 32'h0, rd);
        check("irq_status_rd", rd, 32'h20);
        wb(1'b1, 3'd4, 4'd0, 32'h20, rd);
        @(negedge clk);
        check("irq_cleared", irq, 1'b0);
        wb(1'b0, 3'd4, 4'd0, 32'h0, rd);
        check("irq_status_w1c", rd, 32'h0);
        @(negedge clk);
        s_addr_i = {3'd4, 4'd0}; s_dat_i = 32'h1; s_we_i = 1'b1;
        s_stb_i = 1'b1; s_cyc_i = 1'b1; send_done = 4'b0001;
        @(negedge clk);
        send_done = 4'b0000; s_stb_i = 1'b0; s_cyc_i = 1'b0; s_we_i = 1'b0;
        wb(1'b0, 3'd4, 4'd0, 32'h0, rd);
        check("irq_set_wins", rd, 32'h1);

        // Dropped writes and unmapped reads
        send_fsm_is_ideal = 4'b1110;
        wb(1'b1, 3'd0, 4'd3, 32'h155, rd);
        send_fsm_is_ideal = 4'hF;
        state_reg_enable = 1'b0;
        wb(1'b1, 3'd0, 4'd3, 32'h2AA, rd);
        state_reg_enable = 1'b1;
        wb(1'b0, 3'd0, 4'd3, 32'h0, rd);
        check("size_unchanged", rd, 32'h0);
        check("size_out_unchanged", send_data_size, 40'h0);
        wb(1'b1, 3'd0, 4'd3, 32'h3FF, rd);
        check("size_written", send_data_size, 40'h3FF);
        wb(1'b0, 3'd7, 4'd0, 32'h0, rd);
        check("blk7_read", rd, 32'h0);
        wb(1'b0, 3'd0, 4'd10, 32'h0, rd);
        check("wo_read", rd, 32'h0);

        // Reset asserted mid-access
        @(negedge clk);
        s_addr_i = {3'd0, 4'd5}; s_dat_i = 32'h0F00_0007; s_we_i = 1'b1;
        s_stb_i = 1'b1; s_cyc_i = 1'b1; reset = 1'b0;
        @(negedge clk);
        s_stb_i = 1'b0; s_cyc_i = 1'b0; s_we_i = 1'b0;
        check("mid_rst_ack", s_ack_o, 1'b0);
        check("mid_rst_start", send_start, 4'h0);
        check("mid_rst_dest", dest_e_addr, 16'h0);
        check("mid_rst_weight", weight, 16'h1111);
        check("mid_rst_addr", send_start_addr, 128'h0);
        check("mid_rst_size", send_data_size, 40'h0);
        check("mid_rst_dat", s_dat_o, 32'h0);
        reset = 1'b1;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
